// File: rtl/seg7_scan.sv
// Multiplexed 7-segment driver: scans a shadowed set of BCD digits one slot at a time,
// with per-digit decimal point, leading-zero blanking and enable-gated blanking.
module seg7_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*NUM_DIGITS-1:0] bcd_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    enable_i,
  input  logic                    blank_lz_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    tick_o
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow_bcd_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    on_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    tick;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    cur_blank;
  logic                    zacc;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction

  always_comb begin
    tick    = enable_i && !rst_i && (presc_q == PRESC_LAST);
    presc_d = presc_q;
    idx_d   = idx_q;
    if (enable_i) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
      if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Display data is taken from the pre-edge shadow, so a load on a tick edge shows up one slot later.
  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    an_d      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        cur_digit = shadow_bcd_q[4*i +: 4];
        cur_dp    = shadow_dp_q[i];
        an_d[i]   = 1'b1;
      end
    end
  end

  always_comb begin
    zacc      = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zacc         = zacc && (shadow_bcd_q[4*i +: 4] == 4'd0);
      zero_from[i] = zacc;
    end
    cur_blank = 1'b0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) cur_blank = blank_lz_i && zero_from[i];
    end
    seg_d = cur_blank ? 7'b0000000 : decode(cur_digit);
    dp_d  = cur_dp;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      presc_q      <= '0;
      idx_q        <= '0;
      on_q         <= 1'b0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      an_q         <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      if (load_i) begin
        shadow_bcd_q <= bcd_i;
        shadow_dp_q  <= dp_i;
      end
      // Outputs refresh only at slot boundaries or when the display first comes on.
      if (!enable_i) begin
        on_q  <= 1'b0;
        seg_q <= '0;
        dp_q  <= 1'b0;
        an_q  <= '0;
      end else if (tick || !on_q) begin
        on_q  <= 1'b1;
        seg_q <= seg_d;
        dp_q  <= dp_d;
        an_q  <= an_d;
      end
    end
  end

  assign seg_o  = seg_q;
  assign dp_o   = dp_q;
  assign an_o   = an_q;
  assign tick_o = tick;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized bench for seg7_scan against a digit-array reference model.
module tb_seg7_scan;
  localparam int N = 4;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst, load, en, blz;
  logic [15:0]  bcd;
  logic [3:0]   dp;
  logic [6:0]   seg;
  logic         dpo;
  logic [3:0]   an;
  logic         tick;

  always #5 clk = ~clk;

  seg7_scan #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
    .clk_i(clk), .rst_i(rst), .bcd_i(bcd), .dp_i(dp), .load_i(load),
    .enable_i(en), .blank_lz_i(blz), .seg_o(seg), .dp_o(dpo), .an_o(an), .tick_o(tick)
  );

  int n_checks = 0;
  int n_errors = 0;

  int SEG[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                  'h7F, 'h6F, 'h40, 'h40, 'h40, 'h40, 'h40, 'h40};

  int sh[N];
  int shdp[N];
  int cnt, idx, on;
  int e_seg, e_dp, e_an;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge();
    int old_sh[N];
    int old_dp[N];
    int t, blank, d;
    old_sh = sh;
    old_dp = shdp;
    if (rst) begin
      for (int k = 0; k < N; k++) begin sh[k] = 0; shdp[k] = 0; end
      cnt = 0; idx = 0; on = 0; e_seg = 0; e_dp = 0; e_an = 0;
      return;
    end
    t = (en && cnt == P - 1) ? 1 : 0;
    if (en) begin
      cnt = (cnt + 1) % P;
      if (t != 0) idx = (idx + 1) % N;
    end
    if (!en) begin
      on = 0; e_seg = 0; e_dp = 0; e_an = 0;
    end else if (t != 0 || on == 0) begin
      on = 1;
      d = old_sh[idx];
      blank = (blz && idx > 0) ? 1 : 0;
      for (int k = idx; k < N; k++) if (old_sh[k] != 0) blank = 0;
      e_seg = (blank != 0) ? 0 : SEG[d];
      e_dp  = old_dp[idx];
      e_an  = 1 << idx;
    end
    if (load) begin
      for (int k = 0; k < N; k++) begin
        sh[k]   = int'(bcd[4*k +: 4]);
        shdp[k] = int'(dp[k]);
      end
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    #1 check("tick", 32'(tick), 32'((en && !rst && cnt == P - 1) ? 1 : 0));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("seg", 32'(seg), 32'(e_seg));
    check("an",  32'(an),  32'(e_an));
    check("dp",  32'(dpo), 32'(e_dp));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; load = 1'b1; en = 1'b1; blz = 1'b0; bcd = 16'h9999; dp = 4'hF;
    @(negedge clk);
    run(2);
    check("rst_an_const", 32'(an), 32'd0);

    rst = 1'b0; load = 1'b1; en = 1'b0; bcd = 16'h1234; dp = 4'b0100;
    step();
    load = 1'b0; en = 1'b1;
    step();
    check("first_digit_const", 32'(seg), 32'h66);
    check("first_an_const", 32'(an), 32'h1);
    run(16);

    blz = 1'b1; load = 1'b1; bcd = 16'h0007; dp = 4'b0000; step(); load = 1'b0;
    run(20);
    blz = 1'b0; run(20);
    blz = 1'b1; load = 1'b1; bcd = 16'h00A0; step(); load = 1'b0;
    run(20);

    // load coinciding with a tick
    for (int g = 0; g < 2 * P && cnt != P - 1; g++) step();
    load = 1'b1; bcd = 16'h5678; dp = 4'b1010; step(); load = 1'b0;
    run(12);

    // drop enable mid-slot
    for (int g = 0; g < 2 * P && cnt != 1; g++) step();
    en = 1'b0; run(10);
    check("dis_an_const", 32'(an), 32'd0);
    en = 1'b1; run(12);

    // reset during digit 2 with load asserted
    for (int g = 0; g < 4 * N * P && idx != 2; g++) step();
    rst = 1'b1; load = 1'b1; bcd = 16'h4321; step();
    rst = 1'b0; load = 1'b0; step();
    check("post_rst_seg_const", 32'(seg), 32'h3F);
    check("post_rst_an_const", 32'(an), 32'h1);
    run(3 * P);

    for (int i = 0; i < 2500; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) blz = ~blz;
      for (int k = 0; k < N; k++)
        bcd[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      dp = 4'($urandom_range(0, 15));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
